// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
//  Module   : pll_lock_supervisor
//  Purpose  : Sequences an iCE40 PLL from the free-running reference clock.
//             It holds the PLL in reset, waits for a synchronized LOCK, and
//             requires lock to stay high for a qualification period before
//             it releases the downstream system reset. Lock loss, a lock
//             timeout or a restart request re-resets the PLL. Each re-reset
//             is counted in a saturating relock counter.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock_in      in   reference clock (never the PLL output)
//    reset_n       in   asynchronous active-low reset
//    pll_locked    in   raw PLL LOCK, asynchronous to clock_in
//    restart       in   single-cycle request for a full PLL re-reset
//    pll_resetb    out  PLL RESETB (0 holds the PLL in reset)
//    sys_reset_n   out  active-low system reset, high only in RUN
//    lock_ok       out  1 while in RUN
//    relock_count  out  re-entries into PLL_RESET, saturating
//    timeout_flag  out  sticky WAIT_LOCK timeout indicator
//  Build option
//    PLLSUP_DEGLITCH_EN  when defined, lock loss in RUN is declared only
//                        after DEGLITCH_CYCLES consecutive low cycles
// ============================================================================
module pll_lock_supervisor #(
  parameter int RESET_CYCLES    = 16,
  parameter int LOCK_TIMEOUT    = 12000,
  parameter int STABLE_CYCLES   = 1200,
  parameter int CNT_W           = 8,
  parameter int DEGLITCH_CYCLES = 4
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             pll_locked,
  input  logic             restart,
  output logic             pll_resetb,
  output logic             sys_reset_n,
  output logic             lock_ok,
  output logic [CNT_W-1:0] relock_count,
  output logic             timeout_flag
);

  // One shared counter serves every state, so it is sized for the largest
  // limit it must reach.
  localparam int MAX_AB  = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_ABC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int MAX_ALL = (MAX_ABC > DEGLITCH_CYCLES) ? MAX_ABC : DEGLITCH_CYCLES;
  localparam int CW      = $clog2(MAX_ALL + 1);

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            sync_q1;
  logic            lock_s;
  logic [CNT_W-1:0] relock_next;
  logic            run_loss;

  // Two-flop synchronizer. Every decision below uses lock_s only.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      sync_q1 <= pll_locked;
      lock_s  <= sync_q1;
    end
  end

  assign relock_next = (&relock_count) ? relock_count : relock_count + CNT_W'(1);

`ifdef PLLSUP_DEGLITCH_EN
  // In RUN the idle main counter counts consecutive low cycles.
  assign run_loss = !lock_s && (cnt == CW'(DEGLITCH_CYCLES - 1));
`else
  assign run_loss = !lock_s;
`endif

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state        <= PLL_RESET;
      cnt          <= '0;
      pll_resetb   <= 1'b0;
      sys_reset_n  <= 1'b0;
      lock_ok      <= 1'b0;
      relock_count <= '0;
      timeout_flag <= 1'b0;
    end else if (restart) begin
      // Restart overrides everything, including a same-cycle timeout, and
      // counts as exactly one relock event.
      state        <= PLL_RESET;
      cnt          <= '0;
      pll_resetb   <= 1'b0;
      sys_reset_n  <= 1'b0;
      lock_ok      <= 1'b0;
      relock_count <= relock_next;
    end else begin
      case (state)
        PLL_RESET: begin
          if (cnt == CW'(RESET_CYCLES - 1)) begin
            state      <= WAIT_LOCK;
            cnt        <= '0;
            pll_resetb <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == CW'(LOCK_TIMEOUT)) begin
            state        <= PLL_RESET;
            cnt          <= '0;
            pll_resetb   <= 1'b0;
            timeout_flag <= 1'b1;
            relock_count <= relock_next;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STABLE: begin
          // Any low cycle returns to WAIT_LOCK with a fresh timeout window.
          if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == CW'(STABLE_CYCLES)) begin
            state       <= RUN;
            cnt         <= '0;
            sys_reset_n <= 1'b1;
            lock_ok     <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RUN: begin
          if (run_loss) begin
            state        <= PLL_RESET;
            cnt          <= '0;
            pll_resetb   <= 1'b0;
            sys_reset_n  <= 1'b0;
            lock_ok      <= 1'b0;
            relock_count <= relock_next;
          end
`ifdef PLLSUP_DEGLITCH_EN
          else if (!lock_s) begin
            cnt <= cnt + CW'(1);
          end else begin
            cnt <= '0;
          end
`endif
        end
        default: begin
          state <= PLL_RESET;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
